alu_operand_issue: RTL and testbench
====================================

Name: alu_operand_issue

Overview:
- Operand-issue stage directly upstream of the 32-bit ALU.
- Holds a 32x32 register file with r0 hardwired to zero, plus a writeback port with write-first bypass.
- Reads two source registers per instruction, or substitutes an immediate for source 2, and registers the ALU operands and control.
- Presents them to the ALU through a one-entry valid/ready output stage and keeps a wrapping count of issued operations.

Parameters:
- DATA_W, 32, operand and register width
- NREG, 32, number of architectural registers (address width = log2(NREG) = 5)
- CNT_W, 16, width of the issue counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- wb_en  input  1  register write enable
- wb_addr  input  5  register write address
- wb_data  input  DATA_W  register write data
- in_valid  input  1  instruction present
- in_ready  output  1  stage can accept an instruction this cycle
- in_rs  input  5  source-1 register index
- in_rt  input  5  source-2 register index
- in_imm  input  DATA_W  immediate operand
- in_use_imm  input  1  1 = source 2 is in_imm; 0 = source 2 is reg[in_rt]
- in_ctrl  input  4  {invertA, invertB, operation[1:0]}
- out_valid  output  1  operands valid toward the ALU
- out_ready  input  1  ALU side consumes this cycle
- out_src1  output  DATA_W  to aluSrc1
- out_src2  output  DATA_W  to aluSrc2
- out_invert_a  output  1  to invertA
- out_invert_b  output  1  to invertB
- out_operation  output  2  to operation
- issue_cnt  output  CNT_W  number of completed handshakes on the output side

Behaviour:
- Reset (rst=1 at a rising edge): all registers reg[0..31] ← 0; out_valid ← 0; out_src1, out_src2, out_invert_a, out_invert_b, out_operation ← 0; issue_cnt ← 0.
  - Reset overrides any same-cycle in_valid, wb_en or handshake; nothing is captured or written.
- Register file writes:
  - On a rising edge with wb_en=1 and wb_addr≠0: reg[wb_addr] ← wb_data.
  - Writes to r0 are dropped; r0 always reads 0.
- Operand read is combinational with write-first bypass:
  - op1 = 0 if in_rs=0.
  - Otherwise op1 = wb_data if wb_en and wb_addr=in_rs.
  - Otherwise op1 = reg[in_rs].
  - op2 is formed the same way from in_rt, unless in_use_imm=1, in which case op2 = in_imm and the bypass is irrelevant.
- in_ready = !out_valid || out_ready. This is combinational and depends only on out_valid and out_ready, never on in_valid.
- Accept: when in_valid && in_ready at a rising edge, the output registers capture op1, op2 and in_ctrl, and out_valid ← 1. Latency is exactly 1 cycle from accept to out_valid.
- Drain: if out_valid && out_ready with no accept in the same cycle, out_valid ← 0 and data outputs hold their last value.
- Simultaneous drain and accept: new data is captured, out_valid stays 1, and there is no bubble. Full throughput is 1 operation per cycle.
- Stall: while out_valid && !out_ready, all out_* signals stay bit-stable and in_ready=0.
  - Register writes during a stall do not alter the held operands; the captured values are final.
- issue_cnt increments by 1 on every out_valid && out_ready edge and wraps from 2^CNT_W−1 to 0.
- Pure datapath: no arithmetic is performed. Immediates pass through unmodified, with no sign extension in this block.

Test Plan:
- Reset, then write r5=0x0000_0007 and r6=0xFFFF_FFFE; issue rs=5, rt=6, ctrl=0b0010 with out_ready=1 → one cycle later out_valid=1, src1=0x7, src2=0xFFFFFFFE, operation=2'b10, invertA=invertB=0; issue_cnt=1 after the handshake.
- Write r0=0xDEADBEEF, then issue rs=0, rt=0 → src1=src2=0.
- Bypass: in the same cycle wb_en=1, wb_addr=3, wb_data=0x1234_5678 and issue rs=3, use_imm=1, imm=0xFFFF_0000 → src1=0x12345678, src2=0xFFFF0000.
- Backpressure: hold out_ready=0 and issue two instructions back-to-back → the second waits (in_ready=0), the first outputs stay stable for 4 cycles even with a write to its rs; releasing out_ready delivers both in order on consecutive cycles, with issue_cnt +2.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles → out_valid stays high for 8 consecutive cycles with no bubbles.
- Reset mid-stall: with out_valid=1 and out_ready=0, assert rst for 1 cycle → out_valid=0, issue_cnt=0, all registers read 0 afterwards.
- Counter wrap: force 65536 handshakes → issue_cnt returns to 0.

Source files
------------

// File: rtl/alu_operand_issue.sv
// Operand-issue stage: 32-entry register file (r0 = 0) with write-first bypass, feeding a one-entry output register toward the ALU.
// Accept-to-out_valid latency is 1 cycle; in_ready = !out_valid || out_ready, so operands hold bit-stable while the ALU stalls.
module alu_operand_issue #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREG)-1:0]  in_rs,
  input  logic [$clog2(NREG)-1:0]  in_rt,
  input  logic [DATA_W-1:0]        in_imm,
  input  logic                     in_use_imm,
  input  logic [3:0]               in_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_src1,
  output logic [DATA_W-1:0]        out_src2,
  output logic                     out_invert_a,
  output logic                     out_invert_b,
  output logic [1:0]               out_operation,
  output logic [CNT_W-1:0]         issue_cnt
);

  logic [DATA_W-1:0] rf_q [NREG];

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] op1, op2;
  logic              accept, fire;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid_q && out_ready;

  // Write-first bypass: a same-cycle writeback to a source register wins over the stored value.
  always_comb begin
    op1 = '0;
    op2 = in_imm;
    if (in_rs != '0) begin
      op1 = (wb_en && (wb_addr == in_rs)) ? wb_data : rf_q[in_rs];
    end
    if (!in_use_imm) begin
      op2 = '0;
      if (in_rt != '0) begin
        op2 = (wb_en && (wb_addr == in_rt)) ? wb_data : rf_q[in_rt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    ctrl_d      = ctrl_q;
    cnt_d       = cnt_q;
    if (fire) begin
      out_valid_d = 1'b0;
      cnt_d       = cnt_q + CNT_W'(1);
    end
    // An accept in the drain cycle refills the stage, so there is no bubble.
    if (accept) begin
      out_valid_d = 1'b1;
      src1_d      = op1;
      src2_d      = op2;
      ctrl_d      = in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      ctrl_q      <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      ctrl_q      <= ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_src1      = src1_q;
  assign out_src2      = src2_q;
  assign out_invert_a  = ctrl_q[3];
  assign out_invert_b  = ctrl_q[2];
  assign out_operation = ctrl_q[1:0];
  assign issue_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Bench for alu_operand_issue: directed vector table, stall/stream/reset/wrap sequences, plus a scoreboard on every output handshake.
module tb_alu_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_src1, out_src2;
  logic        out_invert_a, out_invert_b;
  logic [1:0]  out_operation;
  logic [15:0] issue_cnt;

  alu_operand_issue #(.DATA_W(32), .NREG(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_invert_a(out_invert_a), .out_invert_b(out_invert_b),
    .out_operation(out_operation), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference register file and scoreboard
  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  ctrl;
  } exp_t;

  logic [31:0] model [32];
  exp_t        sb [$];
  logic [15:0] exp_cnt = '0;

  function automatic logic [31:0] mop(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_en && wb_addr == idx) return wb_data;
    return model[idx];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (wb_en && wb_addr != 5'd0) begin
      model[wb_addr] = wb_data;
    end
  end

  // Inputs change only just after posedge, so negedge sees what the next posedge samples.
  always @(negedge clk) begin
    exp_t e;
    chk("issue_cnt", 32'(issue_cnt), 32'(exp_cnt));
    if (rst) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_src1", out_src1, e.s1);
          chk("sb_src2", out_src2, e.s2);
          chk("sb_ctrl", 32'({out_invert_a, out_invert_b, out_operation}), 32'(e.ctrl));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        e.s1   = mop(in_rs);
        e.s2   = in_use_imm ? in_imm : mop(in_rt);
        e.ctrl = in_ctrl;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        vld;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic        ui;
    logic [3:0]  ctrl;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vt [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_in();
    in_rs      = 5'($urandom_range(0, 31));
    in_rt      = 5'($urandom_range(0, 31));
    in_imm     = $urandom;
    in_use_imm = 1'($urandom_range(0, 1));
    in_ctrl    = 4'($urandom_range(0, 15));
    wb_en      = 1'($urandom_range(0, 1));
    wb_addr    = 5'($urandom_range(0, 31));
    wb_data    = $urandom;
  endtask

  logic [31:0] snap1, snap2;
  logic [3:0]  snapc;

  initial begin
    vt[0] = '{1'b0, 1'b1, 5'd5, 32'h0000_0007, 5'd0, 5'd0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0};
    vt[1] = '{1'b0, 1'b1, 5'd6, 32'hFFFF_FFFE, 5'd0, 5'd0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd5, 5'd6, 32'h0, 1'b0, 4'b0010, 32'h7, 32'hFFFF_FFFE};
    vt[3] = '{1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 32'h0, 1'b0, 4'b1100, 32'h0, 32'h0};
    vt[5] = '{1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd0, 32'hFFFF_0000, 1'b1, 4'b0101, 32'h1234_5678, 32'hFFFF_0000};
    vt[6] = '{1'b1, 1'b0, 5'd0, 32'h0,         5'd3, 5'd3, 32'h0, 1'b0, 4'b0011, 32'h1234_5678, 32'h1234_5678};
    vt[7] = '{1'b1, 1'b1, 5'd3, 32'hAAAA_5555, 5'd6, 5'd3, 32'h0, 1'b0, 4'b1000, 32'hFFFF_FFFE, 32'hAAAA_5555};
    vt[8] = '{1'b1, 1'b1, 5'd0, 32'h0000_0001, 5'd0, 5'd5, 32'h0, 1'b0, 4'b0110, 32'h0, 32'h7};
    vt[9] = '{1'b1, 1'b1, 5'd7, 32'h0000_0055, 5'd7, 5'd7, 32'h8000_0000, 1'b1, 4'b1111, 32'h55, 32'h8000_0000};

    rst = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    in_valid = 1'b0; in_rs = '0; in_rt = '0; in_imm = '0; in_use_imm = 1'b0; in_ctrl = '0;
    out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_src1", out_src1, 32'd0);
    chk("rst_src2", out_src2, 32'd0);
    chk("rst_ctrl", 32'({out_invert_a, out_invert_b, out_operation}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table, one entry per two cycles with out_ready held high
    step();
    for (int i = 0; i < 10; i++) begin
      in_valid = vt[i].vld; wb_en = vt[i].wen; wb_addr = vt[i].waddr; wb_data = vt[i].wdata;
      in_rs = vt[i].rs; in_rt = vt[i].rt; in_imm = vt[i].imm; in_use_imm = vt[i].ui; in_ctrl = vt[i].ctrl;
      step();
      in_valid = 1'b0; wb_en = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk($sformatf("vec%0d_src1", i), out_src1, vt[i].e1);
        chk($sformatf("vec%0d_src2", i), out_src2, vt[i].e2);
        chk($sformatf("vec%0d_ctrl", i), 32'({out_invert_a, out_invert_b, out_operation}), 32'(vt[i].ctrl));
      end
      step();
    end
    @(negedge clk);
    chk("vec_issue_cnt", 32'(issue_cnt), 32'd7);

    // Backpressure: two back-to-back instructions against a stalled ALU
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs = 5'd5; in_rt = 5'd6; in_use_imm = 1'b0; in_ctrl = 4'b0001;
    step();
    in_rs = 5'd6; in_rt = 5'd5; in_ctrl = 4'b1010;
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0099;
    @(negedge clk);
    snap1 = out_src1; snap2 = out_src2; snapc = {out_invert_a, out_invert_b, out_operation};
    chk("stall_first_src1", out_src1, 32'h7);
    chk("stall_first_src2", out_src2, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_src1", out_src1, snap1);
      chk("stall_src2", out_src2, snap2);
      chk("stall_ctrl", 32'({out_invert_a, out_invert_b, out_operation}), 32'(snapc));
      step();
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_src1", out_src1, 32'hFFFF_FFFE);
    chk("bp_second_src2", out_src2, 32'h0000_0099);
    chk("bp_second_ctrl", 32'({out_invert_a, out_invert_b, out_operation}), 32'b1010);
    step();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_issue_cnt", 32'(issue_cnt), 32'd9);

    // Streaming with random operands and concurrent writebacks
    step();
    in_valid = 1'b1;
    rand_in();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 7) rand_in();
      else begin in_valid = 1'b0; wb_en = 1'b0; end
      @(negedge clk);
      chk("stream_no_bubble", 32'(out_valid), 32'd1);
    end
    step();
    @(negedge clk);
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a stall, with competing input and writeback
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; in_rs = 5'd5; in_rt = 5'd6; in_use_imm = 1'b0; in_ctrl = 4'b0111;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    step();
    rst = 1'b1; in_valid = 1'b1; wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0077;
    step();
    rst = 1'b0; in_valid = 1'b0; wb_en = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(issue_cnt), 32'd0);
    chk("midrst_src1", out_src1, 32'd0);
    chk("midrst_src2", out_src2, 32'd0);
    step();
    out_ready = 1'b1;
    in_valid = 1'b1; in_use_imm = 1'b0; in_ctrl = 4'b0000; in_rs = 5'd1; in_rt = 5'd31;
    for (int r = 1; r < 32; r++) begin
      step();
      if (r < 31) begin in_rs = 5'(r + 1); in_rt = 5'(31 - r); end
      else in_valid = 1'b0;
      @(negedge clk);
      chk("postrst_reg_src1", out_src1, 32'd0);
      chk("postrst_reg_src2", out_src2, 32'd0);
    end

    // Counter wrap
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_use_imm = 1'b1; in_imm = 32'hCAFE_0001; in_rs = 5'd0; in_ctrl = 4'b0100;
    repeat (65535) step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("cnt_max", 32'(issue_cnt), 32'h0000_FFFF);
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("cnt_wrap", 32'(issue_cnt), 32'd0);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
